// File: rtl/spi_txn_arbiter.sv
// Round-robin scheduler sharing a 3-slave SPI subsystem between N_REQ requesters.
// Drives the master tx word and a one-hot chip select for each transaction, then returns the receive word.
module spi_txn_arbiter #(
    parameter int unsigned N_REQ      = 3,
    parameter int unsigned XFER_BITS  = 16,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_REQ-1:0]      req,
    input  logic [2*N_REQ-1:0]    req_sel,
    input  logic [16*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]      gnt,
    output logic [N_REQ-1:0]      done,
    output logic [N_REQ-1:0]      err,
    output logic [15:0]           rsp_data,
    output logic                  busy,
    output logic                  spi_cs1,
    output logic                  spi_cs2,
    output logic                  spi_cs3,
    output logic [15:0]           spi_master_data,
    input  logic [15:0]           spi_master_r
);

    localparam int unsigned DATA_W  = 16;
    localparam int unsigned SEL_W   = 2;
    localparam int unsigned CS_W    = 3;
    localparam int unsigned PTR_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CNT_MAX = (XFER_BITS > GAP_CYCLES) ? XFER_BITS : GAP_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_SHIFT   = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_GAP     = 3'd4
    } state_t;

    state_t              state_q;
    logic [PTR_W-1:0]    ptr_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [N_REQ-1:0]    gnt_q;
    logic [N_REQ-1:0]    done_q;
    logic [N_REQ-1:0]    err_q;
    logic [DATA_W-1:0]   rsp_q;
    logic                busy_q;
    logic [CS_W-1:0]     cs_q;
    logic [DATA_W-1:0]   data_q;

    logic [SEL_W-1:0]    sel_arr  [N_REQ];
    logic [DATA_W-1:0]   data_arr [N_REQ];
    int unsigned         cand_c;
    logic                win_valid_c;
    logic [PTR_W-1:0]    win_idx_c;
    logic [SEL_W-1:0]    win_sel_c;
    logic [DATA_W-1:0]   win_data_c;
    logic [N_REQ-1:0]    win_oh_c;

    always_comb begin
        for (int i = 0; i < int'(N_REQ); i++) begin
            sel_arr[i]  = req_sel[SEL_W*i +: SEL_W];
            data_arr[i] = req_data[DATA_W*i +: DATA_W];
        end
    end

    // Scan starts one past the last winner so a repeat requester yields to everyone else.
    always_comb begin
        cand_c      = 0;
        win_valid_c = 1'b0;
        win_idx_c   = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand_c = 32'(ptr_q) + k;
            if (cand_c >= N_REQ) begin
                cand_c = cand_c - N_REQ;
            end
            if (!win_valid_c && req[PTR_W'(cand_c)]) begin
                win_valid_c = 1'b1;
                win_idx_c   = PTR_W'(cand_c);
            end
        end
        win_sel_c  = sel_arr[win_idx_c];
        win_data_c = data_arr[win_idx_c];
        win_oh_c   = N_REQ'(1) << win_idx_c;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= PTR_W'(N_REQ - 1);
            cnt_q   <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            err_q   <= '0;
            rsp_q   <= '0;
            busy_q  <= 1'b0;
            cs_q    <= '0;
            data_q  <= '0;
        end else begin
            gnt_q  <= '0;
            done_q <= '0;
            err_q  <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (win_valid_c) begin
                        ptr_q <= win_idx_c;
                        if (win_sel_c == SEL_W'(0)) begin
                            err_q <= win_oh_c;
                        end else begin
                            gnt_q   <= win_oh_c;
                            cs_q    <= CS_W'(1) << (win_sel_c - SEL_W'(1));
                            data_q  <= win_data_c;
                            busy_q  <= 1'b1;
                            state_q <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    cnt_q   <= '0;
                    state_q <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (cnt_q == CNT_W'(XFER_BITS - 1)) begin
                        cs_q    <= '0;
                        state_q <= ST_CAPTURE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_CAPTURE: begin
                    rsp_q   <= spi_master_r;
                    done_q  <= N_REQ'(1) << ptr_q;
                    cnt_q   <= '0;
                    state_q <= ST_GAP;
                end
                ST_GAP: begin
                    if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt             = gnt_q;
    assign done            = done_q;
    assign err             = err_q;
    assign rsp_data        = rsp_q;
    assign busy            = busy_q;
    assign spi_cs1         = cs_q[0];
    assign spi_cs2         = cs_q[1];
    assign spi_cs3         = cs_q[2];
    assign spi_master_data = data_q;

endmodule
